// File: rtl/jcs_input_dev_if.sv
// JCSCPU IO bus bundle: control-unit strobes/qualifiers plus the shared data bus.
// The CPU side is the master; an IO device uses the slave view.
interface jcs_input_dev_if;
  logic       io_s;
  logic       io_e;
  logic       io_da;
  logic       io_io;
  logic [7:0] bus_in;
  logic [7:0] bus_out;

  modport master (output io_s, io_e, io_da, io_io, bus_in, input bus_out);
  modport slave  (input io_s, io_e, io_da, io_io, bus_in, output bus_out);
endinterface

// File: rtl/jcs_input_dev.sv
// Keyboard-style input device for the JCSCPU IO bus: switch bytes go into a small FIFO
// that the CPU drains with IN Data and inspects with IN Addr once selected by OUT Addr.
module jcs_input_dev #(
  parameter logic [7:0] DEV_ADDR = 8'h01,
  parameter int         DEPTH    = 4
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic           key_stb,
  input  logic [7:0]     key_data,
  jcs_input_dev_if.slave io,
  output logic           ready,
  output logic           ovf
);

  localparam int            PW         = $clog2(DEPTH);
  localparam int            CW         = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_DATA = 2'd1;
  localparam logic [1:0] RD_STAT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          io_s_q, io_s_d;
  logic          io_e_q, io_e_d;
  logic          selected_q, selected_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    fifo_q [DEPTH];
  logic [7:0]    fifo_d [DEPTH];

  logic       s_rise_s;
  logic       e_fall_s;
  logic       full_s;
  logic       empty_s;
  logic       push_s;
  logic       drop_s;
  logic       pop_s;
  logic       stat_clr_s;
  logic       drive_s;
  logic [4:0] count5_s;
  logic [7:0] status_s;
  logic [7:0] bus_out_s;

  // Strobe edges and FIFO events; fullness is judged on the current count, before any pop.
  always_comb begin
    s_rise_s   = io.io_s & ~io_s_q;
    e_fall_s   = io_e_q & ~io.io_e;
    full_s     = (count_q == COUNT_FULL);
    empty_s    = (count_q == COUNT_ZERO);
    push_s     = key_stb & ~full_s;
    drop_s     = key_stb & full_s;
    pop_s      = e_fall_s & (state_q == RD_DATA) & ~empty_s;
    stat_clr_s = e_fall_s & (state_q == RD_STAT);
  end

  // Next-state logic. The edge detectors keep following the strobes during reset so that
  // a strobe already high when reset drops is not seen as a fresh edge.
  always_comb begin
    io_s_d     = io.io_s;
    io_e_d     = io.io_e;
    selected_d = selected_q;
    state_d    = state_q;
    ovf_d      = ovf_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fifo_d     = fifo_q;
    if (reset) begin
      selected_d = 1'b0;
      state_d    = IDLE;
      ovf_d      = 1'b0;
      head_d     = {PW{1'b0}};
      tail_d     = {PW{1'b0}};
      count_d    = COUNT_ZERO;
    end else begin
      if (s_rise_s && io.io_da && io.io_io) begin
        selected_d = (io.bus_in == DEV_ADDR);
      end else begin
        selected_d = selected_q;
      end

      // Once latched, a read completes on the io_e fall even if the device is deselected.
      case (state_q)
        IDLE: begin
          if (io.io_e && !io.io_io && selected_q) begin
            state_d = io.io_da ? RD_STAT : RD_DATA;
          end else begin
            state_d = IDLE;
          end
        end
        RD_DATA, RD_STAT: begin
          if (e_fall_s) begin
            state_d = IDLE;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = IDLE;
      endcase

      if (push_s) begin
        fifo_d[tail_q] = key_data;
        tail_d         = tail_q + PW'(1);
      end else begin
        tail_d = tail_q;
      end

      if (pop_s) begin
        head_d = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      // A dropped byte outranks a same-cycle status clear.
      if (drop_s) begin
        ovf_d = 1'b1;
      end else if (stat_clr_s) begin
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge CLK) begin
    io_s_q     <= io_s_d;
    io_e_q     <= io_e_d;
    selected_q <= selected_d;
    state_q    <= state_d;
    ovf_q      <= ovf_d;
    head_q     <= head_d;
    tail_q     <= tail_d;
    count_q    <= count_d;
    fifo_q     <= fifo_d;
  end

  // Bus drive is combinational so the value is on the wor bus within the io_e window itself.
  always_comb begin
    count5_s = 5'(count_q);
    status_s = {~empty_s, full_s, ovf_q, count5_s};
    drive_s  = io.io_e & ~io.io_io & (selected_q | (state_q != IDLE));
    if (drive_s) begin
      if (io.io_da) begin
        bus_out_s = status_s;
      end else if (!empty_s) begin
        bus_out_s = fifo_q[head_q];
      end else begin
        bus_out_s = 8'h00;
      end
    end else begin
      bus_out_s = 8'h00;
    end
  end

  assign io.bus_out = bus_out_s;
  assign ready      = ~empty_s;
  assign ovf        = ovf_q;

endmodule
